// File: rtl/lhs_shift_sequencer.sv
// lhs_shift_sequencer
//   Drives the ALU left-hand-side shifter (lhs) to perform a multi-bit shift as a run of
//   1-bit lhs steps, feeding lhs_out back into lhs_in each cycle. With keep_carry=0 the lhs
//   carry is zeroed first (logical shift); with keep_carry=1 the existing carry is shifted
//   in (rotate through a WIDTH+1 bit ring).
//
// Ports
//   alu_clk        ALU clock, all state updates on posedge
//   reset          asynchronous active-high reset
//   start          operation request, sampled only while ready=1
//   dir            0 = shift left, 1 = shift right
//   keep_carry     0 = zero lhs carry before shifting, 1 = use existing carry
//   count          number of 1-bit steps
//   data_in        operand
//   ready          idle, start is accepted
//   done           one-cycle pulse, result/carry_result valid
//   result         lhs_out passthrough
//   carry_result   lhs_carry passthrough
//   lhs_operation  lhs op select: 00 pass, 01 shl, 10 shr, 11 zero
//   lhs_in         lhs data input
//   lhs_out        lhs registered output
//   lhs_carry      lhs registered carry
module lhs_shift_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             alu_clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic             keep_carry,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_result,
  output logic [1:0]       lhs_operation,
  output logic [WIDTH-1:0] lhs_in,
  input  logic [WIDTH-1:0] lhs_out,
  input  logic             lhs_carry
);

  localparam logic [1:0] OpPass = 2'b00;
  localparam logic [1:0] OpShl  = 2'b01;
  localparam logic [1:0] OpShr  = 2'b10;
  localparam logic [1:0] OpZero = 2'b11;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StClear,
    StShift,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opnd_q;
  logic             dir_q;
  logic [CNT_W-1:0] rem_q;
  // High during the first SHIFT cycle, when lhs_in must come from the latched operand.
  logic             first_q;

  always_ff @(posedge alu_clk or posedge reset) begin
    if (reset) begin
      state_q <= StInit;
      opnd_q  <= '0;
      dir_q   <= 1'b0;
      rem_q   <= '0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      first_q <= (state_q != StShift);
      if (state_q == StIdle && start) begin
        opnd_q <= data_in;
        dir_q  <= dir;
        rem_q  <= count;
      end else if (state_q == StShift && rem_q != '0) begin
        rem_q <= rem_q - CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ready         = 1'b0;
    done          = 1'b0;
    lhs_operation = OpPass;
    lhs_in        = lhs_out;
    unique case (state_q)
      // lhs has no reset of its own; zero it once before going idle.
      StInit: begin
        lhs_operation = OpZero;
        state_d       = StIdle;
      end
      StIdle: begin
        ready = 1'b1;
        if (start) begin
          state_d = keep_carry ? StShift : StClear;
        end
      end
      StClear: begin
        lhs_operation = OpZero;
        lhs_in        = opnd_q;
        state_d       = StShift;
      end
      StShift: begin
        // rem_q is only zero here for a zero-count request: single pass-through step.
        if (rem_q == '0) begin
          lhs_operation = OpPass;
        end else begin
          lhs_operation = dir_q ? OpShr : OpShl;
        end
        lhs_in = first_q ? opnd_q : lhs_out;
        if (rem_q <= CNT_W'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StInit;
    endcase
  end

  assign result       = lhs_out;
  assign carry_result = lhs_carry;

endmodule

// File: tb/tb_lhs_shift_sequencer.sv
// Directed bench for lhs_shift_sequencer with a behavioural lhs shifter in the loop.
module tb_lhs_shift_sequencer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             dir = 1'b0;
  logic             keep_carry = 1'b0;
  logic [CNT_W-1:0] count = '0;
  logic [WIDTH-1:0] data_in = '0;
  logic             ready, done, carry_result;
  logic [WIDTH-1:0] result, lhs_in;
  logic [1:0]       lhs_operation;
  logic [WIDTH-1:0] lhs_out;
  logic             lhs_carry;

  int n_checks = 0;
  int n_errors = 0;
  int done_seen = 0;

  always #5 clk = ~clk;

  lhs_shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .alu_clk      (clk),
    .reset        (reset),
    .start        (start),
    .dir          (dir),
    .keep_carry   (keep_carry),
    .count        (count),
    .data_in      (data_in),
    .ready        (ready),
    .done         (done),
    .result       (result),
    .carry_result (carry_result),
    .lhs_operation(lhs_operation),
    .lhs_in       (lhs_in),
    .lhs_out      (lhs_out),
    .lhs_carry    (lhs_carry)
  );

  // Behavioural lhs: registered, no reset.
  always @(posedge clk) begin
    case (lhs_operation)
      2'b00: lhs_out <= lhs_in;
      2'b01: {lhs_carry, lhs_out} <= {lhs_in, lhs_carry};
      2'b10: {lhs_out, lhs_carry} <= {lhs_carry, lhs_in};
      default: begin
        lhs_out   <= '0;
        lhs_carry <= 1'b0;
      end
    endcase
  end

  always @(posedge clk) if (done === 1'b1) done_seen <= done_seen + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents a request at the negedge and returns #1 after the accepting posedge.
  task automatic start_op(input logic [WIDTH-1:0] d, input logic dr, input logic [CNT_W-1:0] c,
                          input logic kp);
    @(negedge clk);
    data_in    = d;
    dir        = dr;
    count      = c;
    keep_carry = kp;
    start      = 1'b1;
    check_eq("ready_before_start", 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, output int cyc);
    cyc = base;
    while (done !== 1'b1 && cyc < 64) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] d, input logic dr,
                        input logic [CNT_W-1:0] c, input logic kp,
                        input logic [WIDTH-1:0] exp_res, input logic exp_c, input int exp_lat);
    int cyc;
    logic [1:0] exp_op;
    start_op(d, dr, c, kp);
    if (!kp) exp_op = 2'b11;
    else if (c == 0) exp_op = 2'b00;
    else exp_op = dr ? 2'b10 : 2'b01;
    check_eq({tag, "_first_op"}, 32'(lhs_operation), 32'(exp_op));
    wait_done(1, cyc);
    check_eq({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check_eq({tag, "_result"}, 32'(result), 32'(exp_res));
    check_eq({tag, "_carry"}, 32'(carry_result), 32'(exp_c));
    @(posedge clk);
    #1;
    check_eq({tag, "_back_idle"}, 32'(ready), 32'd1);
  endtask

  initial begin
    int snap;
    int cyc;

    // 1: reset, one INIT cycle with op=11, then idle with a zeroed lhs.
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("init_op", 32'(lhs_operation), 32'h3);
    check_eq("init_ready", 32'(ready), 32'd0);
    check_eq("init_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    check_eq("idle_ready", 32'(ready), 32'd1);
    check_eq("idle_op", 32'(lhs_operation), 32'h0);
    check_eq("idle_lhs_out", 32'(lhs_out), 32'h00);
    check_eq("idle_carry", 32'(carry_result), 32'd0);
    check_eq("idle_done", 32'(done), 32'd0);

    // 2: logical shl by 3.
    run_op("shl3", 8'h81, 1'b0, 4'd3, 1'b0, 8'h0A, 1'b0, 5);
    // 3: logical shr by 1, then shr with kept carry.
    run_op("shr1", 8'h81, 1'b1, 4'd1, 1'b0, 8'h40, 1'b1, 3);
    run_op("shr1k", 8'h00, 1'b1, 4'd1, 1'b1, 8'h80, 1'b0, 2);
    // 4: set carry=1, then a full 9-bit rotate and a zero-count pass.
    run_op("setc", 8'h01, 1'b1, 4'd1, 1'b0, 8'h00, 1'b1, 3);
    run_op("rot9", 8'h5A, 1'b0, 4'd9, 1'b1, 8'h5A, 1'b1, 10);
    run_op("cnt0", 8'h5A, 1'b0, 4'd0, 1'b1, 8'h5A, 1'b1, 2);

    // 5: start pulses during SHIFT and DONE are ignored.
    start_op(8'h3C, 1'b0, 4'd2, 1'b1);
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(0, cyc);
    check_eq("ign_done", 32'(done), 32'd1);
    check_eq("ign_result", 32'(result), 32'hF2);
    check_eq("ign_carry", 32'(carry_result), 32'd0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    snap = done_seen;
    repeat (5) @(posedge clk);
    #1;
    check_eq("ign_no_second_done", 32'(done_seen), 32'(snap));
    check_eq("ign_ready", 32'(ready), 32'd1);
    check_eq("ign_held_result", 32'(result), 32'hF2);
    run_op("after_ign", 8'h0F, 1'b1, 4'd4, 1'b0, 8'hE0, 1'b1, 6);

    // 6: reset mid-shift aborts without a done.
    snap = done_seen;
    start_op(8'h55, 1'b0, 4'd7, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_eq("abort_op", 32'(lhs_operation), 32'h3);
    check_eq("abort_ready", 32'(ready), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("abort_init_op", 32'(lhs_operation), 32'h3);
    check_eq("abort_init_ready", 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    check_eq("abort_idle_ready", 32'(ready), 32'd1);
    check_eq("abort_lhs_out", 32'(lhs_out), 32'h00);
    check_eq("abort_carry", 32'(carry_result), 32'd0);
    check_eq("abort_no_done", 32'(done_seen), 32'(snap));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
